onn_synapse: RTL

Coupling stage directly upstream of each oscillator neuron in the 3x5 ONN: it takes the 1-bit output oscillations of all N neurons and combines them with a row of signed coupling weights. It produces the 1-bit `nin` oscillation that drives that neuron's phase-difference FSM. Weights are loaded serially through a valid/ready handshake before the network runs. One instance per neuron; all neurons share `sclk`.

---
 rtl/onn_pkg.sv | 25 ++
 rtl/onn_bipolar_sum.sv | 35 +++
 rtl/onn_synapse.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/onn_pkg.sv
// onn_pkg: shared definitions for the oscillatory neural network (ONN).
//   ONN_N / ONN_WW : network size and signed coupling-weight width
//   onn_sum_w()    : width of a bipolar weighted sum that cannot overflow
//   syn_state_t    : synapse weight-load / run state machine encoding
//   onn_weight_t   : signed coupling weight
package onn_pkg;

   localparam int ONN_N  = 15;
   localparam int ONN_WW = 4;

   // N terms of magnitude up to 2^(ww-1) need clog2(n) growth bits plus
   // one more so that +2^(ww-1) (negated most-negative weight) still fits.
   function automatic int onn_sum_w(input int n, input int ww);
      return ww + $clog2(n) + 1;
   endfunction

   typedef enum logic [1:0] {
      SYN_IDLE = 2'd0,
      SYN_LOAD = 2'd1,
      SYN_RUN  = 2'd2
   } syn_state_t;

   typedef logic signed [ONN_WW-1:0] onn_weight_t;

endpackage

// File: rtl/onn_bipolar_sum.sv
// onn_bipolar_sum: combinational bipolar weighted sum.
//   Each oscillator bit selects +w_i (bit=1) or -w_i (bit=0); all terms are
//   sign-extended to SW bits and added.
// Ports:
//   i_osc [N-1:0]          oscillator bits, bit i is neuron i
//   i_w   [N-1:0][WW-1:0]  two's complement weights, entry i pairs with bit i
//   o_sum [SW-1:0]         signed total, two's complement
module onn_bipolar_sum
   import onn_pkg::*;
#(
   parameter int N  = ONN_N,
   parameter int WW = ONN_WW,
   parameter int SW = onn_sum_w(ONN_N, ONN_WW)
) (
   input  logic [N-1:0]         i_osc,
   input  logic [N-1:0][WW-1:0] i_w,
   output logic [SW-1:0]        o_sum
);

   logic [SW-1:0] w_acc;
   logic [SW-1:0] w_ext;

   always_comb begin
      w_acc = '0;
      w_ext = '0;
      for (int i = 0; i < N; i++) begin
         w_ext = {{(SW-WW){i_w[i][WW-1]}}, i_w[i]};
         // Subtracting in SW bits makes -(-2^(WW-1)) a positive value.
         w_acc = i_osc[i] ? (w_acc + w_ext) : (w_acc - w_ext);
      end
   end

   assign o_sum = w_acc;

endmodule

// File: rtl/onn_synapse.sv
// onn_synapse: coupling stage in front of one ONN oscillator neuron.
//   Weights are loaded serially (valid/ready) after a load_start pulse; once
//   the last of N weights is accepted the block runs, forming a registered
//   bipolar weighted sum of all oscillator outputs and a registered sign
//   decision that drives the neuron's phase-difference FSM.
// Configuration macro: ONN_SYNAPSE_TIE_HOLD_EN
//   defined   : sum==0 keeps the previous o_nin
//   undefined : sum==0 drives o_nin=0
// Ports:
//   i_sclk         system clock, rising edge
//   i_re_n         synchronous active-low reset
//   i_osc_in [N]   neuron outputs, synchronous to i_sclk
//   i_load_start   pulse: (re)start a weight load
//   i_w_valid      weight beat valid
//   i_w_data [WW]  signed weight for current index
//   o_w_ready      weight beat accepted this cycle (LOAD state)
//   o_run          weight row complete, o_nin live
//   o_nin          coupled oscillation to the neuron
//   o_sum_out [SW] registered signed weighted sum
module onn_synapse
   import onn_pkg::*;
#(
   parameter int  N  = ONN_N,
   parameter int  WW = ONN_WW,
   localparam int SW = onn_sum_w(N, WW),
   localparam int IW = $clog2(N)
) (
   input  logic          i_sclk,
   input  logic          i_re_n,
   input  logic [N-1:0]  i_osc_in,
   input  logic          i_load_start,
   input  logic          i_w_valid,
   input  logic [WW-1:0] i_w_data,
   output logic          o_w_ready,
   output logic          o_run,
   output logic          o_nin,
   output logic [SW-1:0] o_sum_out
);

   syn_state_t          r_state;
   syn_state_t          w_state_nxt;
   logic [IW-1:0]       r_idx;
   logic [N-1:0][WW-1:0] r_w;
   logic [SW-1:0]       r_sum;
   logic                r_nin;
   logic                w_beat;
   logic                w_last;
   logic [SW-1:0]       w_sum;
   logic                w_dec;

   assign w_last = (r_idx == IW'(N-1));

   // ---------------- FSM ----------------
   always_ff @(posedge i_sclk) begin
      if (!i_re_n) r_state <= SYN_IDLE;
      else         r_state <= w_state_nxt;
   end

   // load_start outranks a coincident beat: the beat is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_beat      = 1'b0;
      if (i_load_start) begin
         w_state_nxt = SYN_LOAD;
      end else begin
         case (r_state)
            SYN_LOAD: begin
               if (i_w_valid) begin
                  w_beat = 1'b1;
                  if (w_last) w_state_nxt = SYN_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_w_ready = (r_state == SYN_LOAD);
   assign o_run     = (r_state == SYN_RUN);

   // ---------------- weight row ----------------
   always_ff @(posedge i_sclk) begin
      if (!i_re_n)                r_idx <= '0;
      else if (i_load_start)      r_idx <= '0;
      else if (w_beat && w_last)  r_idx <= '0;
      else if (w_beat)            r_idx <= r_idx + 1'b1;
   end

   // Old weights survive a reload until their index is rewritten.
   always_ff @(posedge i_sclk) begin
      if (!i_re_n) begin
         r_w <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_beat && (r_idx == IW'(i))) r_w[i] <= i_w_data;
         end
      end
   end

   // ---------------- datapath ----------------
   onn_bipolar_sum #(
      .N  (N),
      .WW (WW),
      .SW (SW)
   ) u_sum (
      .i_osc (i_osc_in),
      .i_w   (r_w),
      .o_sum (w_sum)
   );

   // Summing only while in RUN keeps the partially written row (including
   // the last-beat edge) out of the result.
   always_ff @(posedge i_sclk) begin
      if (!i_re_n)                  r_sum <= '0;
      else if (i_load_start)        r_sum <= '0;
      else if (r_state == SYN_RUN)  r_sum <= w_sum;
      else                          r_sum <= '0;
   end

   always_comb begin
      w_dec = 1'b0;
      if (r_sum[SW-1])      w_dec = 1'b0;
      else if (|r_sum)      w_dec = 1'b1;
      else begin
`ifdef ONN_SYNAPSE_TIE_HOLD_EN
         w_dec = r_nin;
`else
         w_dec = 1'b0;
`endif
      end
   end

   // Outside RUN the decision is held at 0, which also clears the tie hold.
   always_ff @(posedge i_sclk) begin
      if (!i_re_n)                  r_nin <= 1'b0;
      else if (i_load_start)        r_nin <= 1'b0;
      else if (r_state == SYN_RUN)  r_nin <= w_dec;
      else                          r_nin <= 1'b0;
   end

   assign o_sum_out = r_sum;
   assign o_nin     = r_nin;

endmodule
